chroma_qp_inverse_search: RTL

//  Inverse of the forward chroma QP mapping qPi -> QpC.
//  - Given a chroma format and a target QpC, finds the smallest luma-domain qPi whose mapped QpC is >= target.
//  - Flags exact hits and out-of-range misses.
//  - Serves the rate-control / RDOQ QP derivation path.
//  - Sequential linear scan over the forward table, one entry per clock, with early termination.
//  - Valid/ready request and response handshakes.

---
 rtl/chroma_qp_pkg.sv | 24 ++
 rtl/chroma_qp_fwd_lut.sv | 24 ++
 rtl/chroma_qp_inverse_search.sv | 82 ++++++++
 3 files changed

// File: rtl/chroma_qp_pkg.sv
// chroma_qp_pkg: shared types and forward chroma QP tables for the inverse search
package chroma_qp_pkg;

    typedef enum logic [1:0] {FMT_400, FMT_420, FMT_422, FMT_444} chroma_fmt_e;
    typedef enum logic [1:0] {ST_IDLE, ST_SEARCH, ST_DONE} state_e;

    localparam int CHROMA_TABLE_LEN = 58;
    localparam int TBL_AW = $clog2(CHROMA_TABLE_LEN);

    localparam logic [7:0] TBL_420 [CHROMA_TABLE_LEN] = '{
        0, 1, 2, 3, 4, 5, 6, 7, 8, 9, 10, 11, 12, 13, 14, 15, 16, 17, 18, 19,
        20, 21, 22, 23, 24, 25, 26, 27, 28, 29,
        29, 30, 31, 32, 33, 33, 34, 34, 35, 35, 36, 36, 37, 37,
        38, 39, 40, 41, 42, 43, 44, 45, 46, 47, 48, 49, 50, 51
    };

    localparam logic [7:0] TBL_444 [CHROMA_TABLE_LEN] = '{
        0, 1, 2, 3, 4, 5, 6, 7, 8, 9, 10, 11, 12, 13, 14, 15, 16, 17, 18, 19,
        20, 21, 22, 23, 24, 25, 26, 27, 28, 29, 30, 31, 32, 33, 34, 35, 36, 37,
        38, 39, 40, 41, 42, 43, 44, 45, 46, 47, 48, 49, 50, 51,
        51, 51, 51, 51, 51, 51
    };

endpackage

// File: rtl/chroma_qp_fwd_lut.sv
// chroma_qp_fwd_lut: combinational forward chroma QP lookup (fmt, addr) -> QpC
module chroma_qp_fwd_lut
    import chroma_qp_pkg::*;
#(
    parameter int QPC_W = 8,
    parameter int QPI_W = 6
) (
    input  chroma_fmt_e      fmt,
    input  logic [QPI_W-1:0] addr,
    output logic [QPC_W-1:0] data
);

    logic [TBL_AW-1:0] idx;
    logic [7:0] raw;

    always_comb begin
        idx  = TBL_AW'(addr);
        raw  = (32'(addr) >= CHROMA_TABLE_LEN) ? 8'd0 :
               (fmt == FMT_400) ? 8'd0 :
               (fmt == FMT_420) ? TBL_420[idx] : TBL_444[idx];
        data = QPC_W'(raw);
    end

endmodule

// File: rtl/chroma_qp_inverse_search.sv
// chroma_qp_inverse_search: linear scan for the smallest qPi whose forward QpC reaches a target
module chroma_qp_inverse_search
    import chroma_qp_pkg::*;
#(
    parameter int TABLE_LEN = 58,
    parameter int QPC_W     = 8,
    localparam int QPI_W    = $clog2(TABLE_LEN)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic [1:0]       req_fmt,
    input  logic [QPC_W-1:0] req_qpc,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic [QPI_W-1:0] rsp_qpi,
    output logic             rsp_exact,
    output logic             rsp_miss,
    output logic             busy
);

    localparam logic [QPI_W-1:0] LAST = QPI_W'(TABLE_LEN - 1);

    state_e           state;
    chroma_fmt_e      fmt_q;
    logic [QPC_W-1:0] qpc_q;
    logic [QPI_W-1:0] addr;
    logic [QPC_W-1:0] d;

    chroma_qp_fwd_lut #(.QPC_W(QPC_W), .QPI_W(QPI_W)) u_lut (
        .fmt  (fmt_q),
        .addr (addr),
        .data (d)
    );

    assign req_ready = (state == ST_IDLE) || ((state == ST_DONE) && rsp_ready);
    assign rsp_valid = (state == ST_DONE);
    assign busy      = (state != ST_IDLE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= ST_IDLE;
            fmt_q     <= FMT_400;
            qpc_q     <= '0;
            addr      <= '0;
            rsp_qpi   <= '0;
            rsp_exact <= 1'b0;
            rsp_miss  <= 1'b0;
        end else begin
            case (state)
                ST_SEARCH: begin
                    if (d >= qpc_q) begin
                        rsp_qpi   <= addr;
                        rsp_exact <= (d == qpc_q);
                        rsp_miss  <= 1'b0;
                        state     <= ST_DONE;
                    end else if (addr == LAST) begin
                        rsp_qpi   <= LAST;
                        rsp_exact <= 1'b0;
                        rsp_miss  <= 1'b1;
                        state     <= ST_DONE;
                    end else begin
                        addr <= addr + 1'b1;
                    end
                end
                default: begin
                    // IDLE, or DONE being drained: a pending request starts a new scan with no bubble
                    if (req_ready && req_valid) begin
                        fmt_q <= chroma_fmt_e'(req_fmt);
                        qpc_q <= req_qpc;
                        addr  <= '0;
                        state <= ST_SEARCH;
                    end else if (state == ST_DONE && rsp_ready) begin
                        state <= ST_IDLE;
                    end
                end
            endcase
        end
    end

endmodule
